// File: rtl/predictor_state_update_pkg.sv
// Shared Q-format constants, FSM encoding, default coefficients and the
// output saturation helper for the predictor state-update stage.
package predictor_pkg;

    localparam int FRAC_IN  = 32;                   // Q32.32 terms
    localparam int FRAC_OUT = 16;                   // Q16.16 results
    localparam int ACC_W    = 100;                  // accumulator width
    localparam int PROD_W   = 97;                   // 33s x 64s product
    localparam int COEF_W   = 33;                   // Q1.32 coefficients
    localparam int TERM_W   = 64;
    localparam int Y_W      = 32;
    localparam int Q_LSB    = 2 * FRAC_IN - FRAC_OUT;  // 48: weight 2^-16 in Q.64
    localparam int Q_MSB    = Q_LSB + Y_W - 1;         // 79

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_SAT,
        ST_DONE
    } state_e;

    localparam logic signed [COEF_W-1:0] A00_DEF =  33'sd4172793605;
    localparam logic signed [COEF_W-1:0] A01_DEF =  33'sd4233586;
    localparam logic signed [COEF_W-1:0] A10_DEF = -33'sd4233586;
    localparam logic signed [COEF_W-1:0] A11_DEF =  33'sd4172793605;
    localparam logic signed [COEF_W-1:0] B0_DEF  =  33'sd214748365;
    localparam logic signed [COEF_W-1:0] B1_DEF  =  33'sd0;

    // Floor to Q16.16 by taking acc[79:48]; clamp when the bits above the
    // sign of the result disagree (value outside the Q16.16 range).
    function automatic logic [Y_W-1:0] sat_q16(input logic signed [ACC_W-1:0] acc);
        logic [Y_W-1:0] r;
        if (acc[ACC_W-1:Q_MSB] == {(ACC_W-Q_MSB){acc[ACC_W-1]}})
            r = acc[Q_MSB:Q_LSB];
        else if (!acc[ACC_W-1])
            r = 32'h7FFF_FFFF;
        else
            r = 32'h8000_0000;
        return r;
    endfunction

endpackage

// File: rtl/predictor_state_update_if.sv
// ap_ctrl_hs handshake plus data ports of the predictor state-update stage.
interface predictor_state_update_if;
    import predictor_pkg::*;

    logic              ap_start;
    logic              ap_ready;
    logic              ap_idle;
    logic              ap_done;
    logic [TERM_W-1:0] temp1_0;
    logic [TERM_W-1:0] temp1_1;
    logic [Y_W-1:0]    u;
    logic [Y_W-1:0]    y0_out;
    logic [Y_W-1:0]    y1_out;
    logic              y_out_ap_vld;

    modport master (
        output ap_start, temp1_0, temp1_1, u,
        input  ap_ready, ap_idle, ap_done, y0_out, y1_out, y_out_ap_vld
    );

    modport slave (
        input  ap_start, temp1_0, temp1_1, u,
        output ap_ready, ap_idle, ap_done, y0_out, y1_out, y_out_ap_vld
    );

endinterface

// File: rtl/predictor_state_update_mul_33s_64s_97.sv
// Fully pipelined signed 33 x 64 multiplier; result appears LAT cycles
// after the operands are presented. Pure datapath, so no reset.
module predictor_state_update_mul_33s_64s_97
    import predictor_pkg::*;
#(
    parameter int LAT = 5
) (
    input  logic                     clk,
    input  logic                     ce,
    input  logic signed [COEF_W-1:0] a,
    input  logic signed [TERM_W-1:0] b,
    output logic signed [PROD_W-1:0] p
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] pipe_d [LAT];
    logic signed [PROD_W-1:0] pipe_q [LAT];

    // Product enters stage 0; later stages are plain delay for retiming.
    always_comb begin
        a_ext     = {{(PROD_W-COEF_W){a[COEF_W-1]}}, a};
        b_ext     = {{(PROD_W-TERM_W){b[TERM_W-1]}}, b};
        pipe_d[0] = a_ext * b_ext;
        for (int i = 1; i < LAT; i++)
            pipe_d[i] = pipe_q[i-1];
    end

    // Advance the pipeline whenever enabled.
    always_ff @(posedge clk) begin
        if (ce)
            pipe_q <= pipe_d;
    end

    assign p = pipe_q[LAT-1];

endmodule

// File: rtl/predictor_state_update.sv
// Next-state predictor: y0 = A00*t0 + A01*t1 + B0*u, y1 = A10*t0 + A11*t1 + B1*u.
// Six products share one pipelined multiplier; a valid/tag pipe routes each
// emerging product into acc0 or acc1, then both are floored and saturated
// to Q16.16.
module predictor_state_update
    import predictor_pkg::*;
#(
    parameter int                      MUL_LAT = 5,
    parameter logic signed [COEF_W-1:0] A00    = A00_DEF,
    parameter logic signed [COEF_W-1:0] A01    = A01_DEF,
    parameter logic signed [COEF_W-1:0] A10    = A10_DEF,
    parameter logic signed [COEF_W-1:0] A11    = A11_DEF,
    parameter logic signed [COEF_W-1:0] B0     = B0_DEF,
    parameter logic signed [COEF_W-1:0] B1     = B1_DEF
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    predictor_state_update_if.slave bus
);

    localparam logic [MUL_LAT-1:0] TOP_BIT = MUL_LAT'(1) << (MUL_LAT - 1);

    state_e                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic signed [TERM_W-1:0]  t0_q, t0_d, t1_q, t1_d, uext_q, uext_d;
    logic signed [ACC_W-1:0]   acc0_q, acc0_d, acc1_q, acc1_d;
    logic [MUL_LAT-1:0]        vld_pipe_q, vld_pipe_d;
    logic [MUL_LAT-1:0]        tag_pipe_q, tag_pipe_d;
    logic [Y_W-1:0]            y0_q, y0_d, y1_q, y1_d;
    logic                      done_q, done_d;

    logic                      accept;
    logic                      issue;
    logic                      issue_tag;
    logic                      drain_last;
    logic signed [COEF_W-1:0]  mul_a;
    logic signed [TERM_W-1:0]  mul_b;
    logic signed [PROD_W-1:0]  mul_p;
    logic signed [ACC_W-1:0]   prod_ext;

    assign accept     = (state_q == ST_IDLE) && bus.ap_start;
    // Last in-flight product sits in the final stage: accs complete next cycle.
    assign drain_last = (vld_pipe_q & ~TOP_BIT) == '0;

    // Pick operands for the product numbered by the issue counter.
    always_comb begin
        issue     = (state_q == ST_ISSUE);
        issue_tag = (cnt_q >= 3'd4);
        mul_a     = '0;
        mul_b     = '0;
        case (cnt_q)
            3'd1: begin mul_a = A00; mul_b = t0_q;   end
            3'd2: begin mul_a = A01; mul_b = t1_q;   end
            3'd3: begin mul_a = B0;  mul_b = uext_q; end
            3'd4: begin mul_a = A10; mul_b = t0_q;   end
            3'd5: begin mul_a = A11; mul_b = t1_q;   end
            3'd6: begin mul_a = B1;  mul_b = uext_q; end
            default: ;
        endcase
    end

    predictor_state_update_mul_33s_64s_97 #(.LAT(MUL_LAT)) u_mul (
        .clk (ap_clk),
        .ce  (1'b1),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    // Control FSM next state, operand latching and output registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        uext_d  = uext_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ap_start) begin
                    t0_d    = bus.temp1_0;
                    t1_d    = bus.temp1_1;
                    uext_d  = {{16{bus.u[Y_W-1]}}, bus.u, 16'h0000};
                    cnt_d   = 3'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 3'd6)
                    state_d = ST_DRAIN;
                else
                    cnt_d = cnt_q + 3'd1;
            end
            ST_DRAIN: begin
                if (drain_last)
                    state_d = ST_SAT;
            end
            ST_SAT: begin
                y0_d    = sat_q16(acc0_q);
                y1_d    = sat_q16(acc1_q);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            // Output-valid cycle; keeps a held ap_start from being taken now.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Valid/tag tracking of in-flight products and accumulation on emergence.
    always_comb begin
        vld_pipe_d[0] = issue;
        tag_pipe_d[0] = issue_tag;
        for (int i = 1; i < MUL_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
        prod_ext = {{(ACC_W-PROD_W){mul_p[PROD_W-1]}}, mul_p};
        acc0_d   = acc0_q;
        acc1_d   = acc1_q;
        if (accept) begin
            acc0_d = '0;
            acc1_d = '0;
        end else if (vld_pipe_q[MUL_LAT-1]) begin
            if (tag_pipe_q[MUL_LAT-1])
                acc1_d = acc1_q + prod_ext;
            else
                acc0_d = acc0_q + prod_ext;
        end
    end

    // State registers; reset aborts any run and drops in-flight products.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            uext_q     <= '0;
            acc0_q     <= '0;
            acc1_q     <= '0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            uext_q     <= uext_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            done_q     <= done_d;
        end
    end

    assign bus.ap_ready     = accept;
    assign bus.ap_idle      = (state_q == ST_IDLE) && !bus.ap_start;
    assign bus.ap_done      = done_q;
    assign bus.y_out_ap_vld = done_q;
    assign bus.y0_out       = y0_q;
    assign bus.y1_out       = y1_q;

endmodule

// File: tb/tb_predictor_state_update.sv
// Directed and random checks of predictor_state_update against an
// independent 100-bit reference model.
module tb_predictor_state_update;

    localparam logic signed [32:0] C_A00 =  33'sd4172793605;
    localparam logic signed [32:0] C_A01 =  33'sd4233586;
    localparam logic signed [32:0] C_A10 = -33'sd4233586;
    localparam logic signed [32:0] C_A11 =  33'sd4172793605;
    localparam logic signed [32:0] C_B0  =  33'sd214748365;
    localparam logic signed [32:0] C_B1  =  33'sd0;

    logic ap_clk;
    logic ap_rst;
    int   n_chk;
    int   n_err;

    predictor_state_update_if bus_if ();

    predictor_state_update dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus_if)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    function automatic logic signed [99:0] sx33(input logic signed [32:0] c);
        logic signed [99:0] r;
        r = {{67{c[32]}}, c};
        return r;
    endfunction

    function automatic logic [31:0] clamp(input logic signed [99:0] s);
        logic signed [99:0] fl;
        fl = s >>> 48;
        if (fl > 100'sh7FFFFFFF)          return 32'h7FFF_FFFF;
        if (fl < -100'sd2147483648)       return 32'h8000_0000;
        return fl[31:0];
    endfunction

    task automatic model(input logic [63:0] t0, input logic [63:0] t1, input logic [31:0] uu,
                         output logic [31:0] y0, output logic [31:0] y1);
        logic signed [99:0] e0, e1, eu, s0, s1;
        e0 = {{36{t0[63]}}, t0};
        e1 = {{36{t1[63]}}, t1};
        eu = {{52{uu[31]}}, uu, 16'h0000};
        s0 = sx33(C_A00) * e0 + sx33(C_A01) * e1 + sx33(C_B0) * eu;
        s1 = sx33(C_A10) * e0 + sx33(C_A11) * e1 + sx33(C_B1) * eu;
        y0 = clamp(s0);
        y1 = clamp(s1);
    endtask

    // Launch one request, scramble inputs after acceptance, wait for ap_done.
    task automatic run(input logic [63:0] t0, input logic [63:0] t1, input logic [31:0] uu,
                       output int lat, output logic [31:0] y0, output logic [31:0] y1);
        bus_if.temp1_0  = t0;
        bus_if.temp1_1  = t1;
        bus_if.u        = uu;
        bus_if.ap_start = 1'b1;
        #1;
        chk("accept_ready", {63'b0, bus_if.ap_ready}, 64'd1);
        tick();
        bus_if.ap_start = 1'b0;
        bus_if.temp1_0  = {$urandom, $urandom};
        bus_if.temp1_1  = {$urandom, $urandom};
        bus_if.u        = $urandom;
        lat = 1;
        while (!bus_if.ap_done && lat < 40) begin
            tick();
            lat++;
        end
        chk("done_seen", {63'b0, bus_if.ap_done}, 64'd1);
        chk("y_vld", {63'b0, bus_if.y_out_ap_vld}, 64'd1);
        y0 = bus_if.y0_out;
        y1 = bus_if.y1_out;
        tick();
        chk("done_pulse", {63'b0, bus_if.ap_done}, 64'd0);
        chk("y0_hold", {32'b0, bus_if.y0_out}, {32'b0, y0});
    endtask

    initial begin
        int          lat, nready, ndone, cyc;
        logic [31:0] y0, y1, e0, e1;
        logic [63:0] rt0, rt1;
        logic [31:0] ru;

        n_chk = 0;
        n_err = 0;
        ap_rst          = 1'b1;
        bus_if.ap_start = 1'b0;
        bus_if.temp1_0  = '0;
        bus_if.temp1_1  = '0;
        bus_if.u        = '0;
        tick();
        tick();
        ap_rst = 1'b0;
        #1;
        chk("rst_idle",  {63'b0, bus_if.ap_idle},  64'd1);
        chk("rst_done",  {63'b0, bus_if.ap_done},  64'd0);
        chk("rst_ready", {63'b0, bus_if.ap_ready}, 64'd0);
        chk("rst_y0",    {32'b0, bus_if.y0_out},   64'd0);
        chk("rst_y1",    {32'b0, bus_if.y1_out},   64'd0);
        tick();

        // 1: t0 = 1.0
        run(64'h1_0000_0000, 64'h0, 32'h0, lat, y0, y1);
        chk("c1_lat", 64'(lat), 64'd13);
        chk("c1_y0", {32'b0, y0}, 64'h0000_F8B7);
        chk("c1_y1", {32'b0, y1}, 64'hFFFF_FFBF);

        // 2: u = 1.0
        run(64'h0, 64'h0, 32'h0001_0000, lat, y0, y1);
        chk("c2_y0", {32'b0, y0}, 64'h0000_0CCC);
        chk("c2_y1", {32'b0, y1}, 64'h0);

        // 3: both outputs saturate
        run(64'h7FFF_FFFF_0000_0000, 64'h0, 32'h0, lat, y0, y1);
        chk("c3_y0", {32'b0, y0}, 64'h7FFF_FFFF);
        chk("c3_y1", {32'b0, y1}, 64'h8000_0000);

        // 4: ap_start held high across a whole run
        bus_if.temp1_0  = 64'h0;
        bus_if.temp1_1  = 64'h0;
        bus_if.u        = 32'h0001_0000;
        bus_if.ap_start = 1'b1;
        #1;
        chk("c4_ready0", {63'b0, bus_if.ap_ready}, 64'd1);
        nready = 0;
        cyc    = 0;
        while (!bus_if.ap_done && cyc < 40) begin
            tick();
            cyc++;
            if (bus_if.ap_ready) nready++;
        end
        chk("c4_done_seen", {63'b0, bus_if.ap_done}, 64'd1);
        chk("c4_busy_ready", 64'(nready), 64'd0);
        chk("c4_y0", {32'b0, bus_if.y0_out}, 64'h0000_0CCC);
        tick();
        chk("c4_reaccept", {63'b0, bus_if.ap_ready}, 64'd1);
        tick();
        bus_if.ap_start = 1'b0;
        cyc = 0;
        while (!bus_if.ap_done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("c4_second_done", {63'b0, bus_if.ap_done}, 64'd1);
        chk("c4_second_lat", 64'(cyc + 1), 64'd13);
        tick();

        // 5: reset at cycle 5 of a run aborts it
        bus_if.temp1_0  = 64'h7FFF_FFFF_0000_0000;
        bus_if.temp1_1  = 64'h0;
        bus_if.u        = 32'h0;
        bus_if.ap_start = 1'b1;
        tick();
        bus_if.ap_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        #1;
        chk("c5_y0",   {32'b0, bus_if.y0_out},  64'd0);
        chk("c5_y1",   {32'b0, bus_if.y1_out},  64'd0);
        chk("c5_idle", {63'b0, bus_if.ap_idle}, 64'd1);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_if.ap_done) ndone++;
        end
        chk("c5_no_done", 64'(ndone), 64'd0);
        run(64'h1_0000_0000, 64'h0, 32'h0, lat, y0, y1);
        chk("c5_y0_after", {32'b0, y0}, 64'h0000_F8B7);
        chk("c5_y1_after", {32'b0, y1}, 64'hFFFF_FFBF);

        // 6: random runs against the reference model
        for (int n = 0; n < 1000; n++) begin
            rt0 = {$urandom, $urandom};
            rt1 = {$urandom, $urandom};
            ru  = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    rt0 = 64'($signed(rt0) >>> 20);
                    rt1 = 64'($signed(rt1) >>> 20);
                    ru  = 32'($signed(ru) >>> 4);
                end
                2: begin
                    rt0 = 64'($signed(rt0) >>> 30);
                    rt1 = 64'($signed(rt1) >>> 16);
                    ru  = 32'($signed(ru) >>> 12);
                end
                default: begin
                    rt0 = 64'($signed(rt0) >>> 17);
                    rt1 = 64'($signed(rt1) >>> 17);
                end
            endcase
            model(rt0, rt1, ru, e0, e1);
            run(rt0, rt1, ru, lat, y0, y1);
            chk("rnd_y0", {32'b0, y0}, {32'b0, e0});
            chk("rnd_y1", {32'b0, y1}, {32'b0, e1});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
